spi_regfile_peripheral: RTL and testbench
=========================================

Name: spi_regfile_peripheral

Overview:
Parametrised SPI mode-0 peripheral that exposes a NUM_REGS x DATA_W register file to an external SPI controller. It succeeds the fixed 5-register write-only SPI block. New capabilities:
- read-back over CIPO
- per-register write strobes
- frame-length error detection and counting
- configurable synchroniser depth

It sits between the chip pins (sclk/cs_n/copi/cipo) and the PWM/output-enable logic, all in the single system clock domain.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, data field width and register width
NUM_REGS, 5, number of implemented registers at addresses 0..NUM_REGS-1 (1..2^ADDR_W)
SYNC_STAGES, 2, flops per input synchroniser (>=2)
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sclk  in  1  SPI clock, async, CPOL=0
cs_n  in  1  SPI chip select, async, active-low
copi  in  1  SPI controller-out data, async
cipo  out  1  SPI peripheral-out data (registered)
cipo_oe  out  1  output enable for cipo pad; high only while frame is active
regs_out  out  NUM_REGS*DATA_W  flat register file; reg i at [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-cycle pulse on bit i when reg i is updated
frame_err  out  1  one-cycle pulse on a rejected frame
err_count  out  ERR_W  saturating count of rejected frames

Behaviour:
Reset and synchronisation:
- Reset values: regs_out=0, wr_strobe=0, frame_err=0, err_count=0, cipo=0, cipo_oe=0, state IDLE, armed=0.
- Synchroniser reset values: sclk chain 0, cs_n chain 1, copi chain 0.
- sclk, cs_n and copi each pass through SYNC_STAGES flops. One extra history flop on synced sclk and synced cs_n gives rise/fall detection.
- Timing requirement on the host: sclk high and low times >= SYNC_STAGES+3 clk periods, and copi stable around sclk rise.

Frame format:
- F = 1+ADDR_W+DATA_W bits, MSB first: [RW][ADDR][DATA].
- RW=1 is a write; RW=0 is a read (DATA bits are don't-care).

State machine:
- armed is set the first cycle synced cs_n is 1 after reset. Frames start only when armed, so a cs_n held low through reset never starts a frame.
- IDLE -> ACTIVE on synced cs_n fall while armed. On entry: bit_cnt=0, shift reg=0, cipo_oe=1.
- ACTIVE, each synced sclk rise: shift in synced copi; bit_cnt increments, saturating at F+1.
- When bit_cnt reaches 1+ADDR_W on a read: load the read shifter with reg[ADDR], or 0 if ADDR>=NUM_REGS.
- ACTIVE, each synced sclk fall: if the read shifter is loaded, cipo takes its next bit (MSB first). Otherwise cipo=0.
- ACTIVE -> IDLE on synced cs_n rise. cipo and cipo_oe drop to 0 the same cycle.
- Simultaneous synced sclk edge and cs_n rise: the cs_n rise wins and the sclk edge is ignored.

Commit on cs_n rise:
- bit_cnt==F, RW=1, ADDR<NUM_REGS: reg[ADDR] is written on the next clk edge. wr_strobe[ADDR] pulses in the same cycle the new value first appears.
- bit_cnt==F, ADDR>=NUM_REGS: the frame is silently discarded. No error is raised.
- bit_cnt==F, RW=0: no register change.
- bit_cnt!=F (short frame, or long frame with bit_cnt saturated at F+1): no write. frame_err pulses one cycle. err_count increments, saturating at 2^ERR_W-1.
- Latency: regs_out updates exactly SYNC_STAGES+2 clk edges after the first clk edge that samples cs_n pin high.

Other rules:
- At most one wr_strobe bit is high in any cycle.
- Reset mid-frame discards the partial frame and clears all state. There is no spurious commit or error.
- Registers are never written by read frames. regs_out holds its value between writes.

Test Plan:
- Write RW=1, ADDR=2, DATA=0xA5 (16 bits) -> regs_out[23:16]=0xA5, wr_strobe=5'b00100 for one cycle at SYNC_STAGES+2 clk after cs_n rise; other regs 0.
- Write reg0=0x3C, then read ADDR=0 -> cipo shifts 0,0,1,1,1,1,0,0 on the last 8 sclk falls; cipo_oe=1 only while cs_n is low; regs unchanged.
- Read ADDR=0x7F (unmapped) -> cipo all 0; write to ADDR=0x10 -> no regs change, no frame_err.
- 15-bit write frame, then 17-bit write frame -> regs unchanged; frame_err pulses twice; err_count=2.
- 256 consecutive 3-bit frames with ERR_W=8 -> err_count saturates at 255.
- Assert rst after 9 bits of a write to ADDR=1 while cs_n stays low, release, then complete the frame -> no write and no error. A fresh full frame after cs_n toggles high then low writes correctly.

Source files
------------

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a NUM_REGS x DATA_W register file with read-back,
// per-register write strobes and a saturating frame-error counter, all in the clk domain.
module spi_regfile_peripheral #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err,
    output logic [ERR_W-1:0]             err_count
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [NUM_REGS-1:0] decode_addr(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] sel;
        sel = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = (addr == ADDR_W'(i));
        end
        return sel;
    endfunction

    // An all-zero select (unmapped address) naturally reads back as zero.
    function automatic logic [DATA_W-1:0] read_mux(input logic [NUM_REGS-1:0]        sel,
                                                   input logic [NUM_REGS*DATA_W-1:0] regs);
        logic [DATA_W-1:0] data;
        data = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            data = data | (sel[i] ? regs[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
        return data;
    endfunction

    logic [SYNC_STAGES-1:0]      r_sclk_sync;
    logic [SYNC_STAGES-1:0]      r_cs_sync;
    logic [SYNC_STAGES-1:0]      r_copi_sync;
    logic [SYNC_STAGES-1:0]      r_cs_vld;
    logic                        r_sclk_hist;
    logic                        r_cs_hist;

    state_t                      r_state;
    logic                        r_armed;
    logic [CNT_W-1:0]            r_bit_cnt;
    logic [FRAME_W-1:0]          r_shift;
    logic [DATA_W-1:0]           r_rd_shift;
    logic                        r_rd_loaded;
    logic                        r_cipo;
    logic                        r_cipo_oe;
    logic [NUM_REGS-1:0]         r_wr_sel;
    logic [DATA_W-1:0]           r_wr_data;
    logic                        r_err_pend;

    logic [NUM_REGS*DATA_W-1:0]  r_regs;
    logic [NUM_REGS-1:0]         r_wr_strobe;
    logic                        r_frame_err;
    logic [ERR_W-1:0]            r_err_count;

    logic                        w_sclk_s;
    logic                        w_cs_s;
    logic                        w_copi_s;
    logic                        w_cs_valid;
    logic                        w_sclk_rise;
    logic                        w_sclk_fall;
    logic                        w_cs_rise;
    logic                        w_cs_fall;
    logic [FRAME_W-1:0]          w_shift_next;
    logic [CNT_W-1:0]            w_cnt_next;
    logic                        w_frame_rw;
    logic [ADDR_W-1:0]           w_frame_addr;
    logic [DATA_W-1:0]           w_frame_data;
    logic                        w_nxt_rw;
    logic [ADDR_W-1:0]           w_nxt_addr;

    // Input synchronisers plus one history flop for edge detection on sclk and cs_n.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_copi_sync <= {SYNC_STAGES{1'b0}};
            r_cs_vld    <= {SYNC_STAGES{1'b0}};
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_cs_vld    <= {r_cs_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    // r_cs_vld marks when the cs_n chain holds pin samples rather than reset seed values.
    assign w_cs_valid  = r_cs_vld[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
    assign w_cs_rise   = w_cs_s & ~r_cs_hist;
    assign w_cs_fall   = ~w_cs_s & r_cs_hist;

    assign w_shift_next = {r_shift[FRAME_W-2:0], w_copi_s};
    assign w_cnt_next   = (r_bit_cnt == CNT_SAT) ? CNT_SAT : (r_bit_cnt + CNT_W'(1));
    assign w_frame_rw   = r_shift[FRAME_W-1];
    assign w_frame_addr = r_shift[DATA_W +: ADDR_W];
    assign w_frame_data = r_shift[DATA_W-1:0];
    assign w_nxt_rw     = w_shift_next[ADDR_W];
    assign w_nxt_addr   = w_shift_next[ADDR_W-1:0];

    // Frame state machine: shifting, read-back serialisation and commit decision on cs_n rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_shift     <= {FRAME_W{1'b0}};
            r_rd_shift  <= {DATA_W{1'b0}};
            r_rd_loaded <= 1'b0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            r_wr_sel    <= {NUM_REGS{1'b0}};
            r_wr_data   <= {DATA_W{1'b0}};
            r_err_pend  <= 1'b0;
        end else begin
            r_wr_sel   <= {NUM_REGS{1'b0}};
            r_err_pend <= 1'b0;
            r_armed    <= r_armed | (w_cs_valid & w_cs_s);
            case (r_state)
                ST_IDLE: begin
                    r_cipo    <= 1'b0;
                    r_cipo_oe <= 1'b0;
                    if (w_cs_fall && r_armed) begin
                        r_state     <= ST_ACTIVE;
                        r_bit_cnt   <= {CNT_W{1'b0}};
                        r_shift     <= {FRAME_W{1'b0}};
                        r_rd_shift  <= {DATA_W{1'b0}};
                        r_rd_loaded <= 1'b0;
                        r_cipo_oe   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // cs_n rise takes priority over any coincident sclk edge.
                    if (w_cs_rise) begin
                        r_state     <= ST_IDLE;
                        r_cipo      <= 1'b0;
                        r_cipo_oe   <= 1'b0;
                        r_rd_loaded <= 1'b0;
                        if (r_bit_cnt == CNT_FULL) begin
                            r_wr_sel  <= w_frame_rw ? decode_addr(w_frame_addr) : {NUM_REGS{1'b0}};
                            r_wr_data <= w_frame_data;
                        end else begin
                            r_err_pend <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= w_cnt_next;
                        if ((w_cnt_next == CNT_ADDR) && (r_bit_cnt != CNT_ADDR) && !w_nxt_rw) begin
                            r_rd_shift  <= read_mux(decode_addr(w_nxt_addr), r_regs);
                            r_rd_loaded <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_rd_loaded) begin
                            r_cipo     <= r_rd_shift[DATA_W-1];
                            r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
                        end else begin
                            r_cipo <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cipo    <= 1'b0;
                    r_cipo_oe <= 1'b0;
                end
            endcase
        end
    end

    // Register file update, strobes, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs      <= {(NUM_REGS*DATA_W){1'b0}};
            r_wr_strobe <= {NUM_REGS{1'b0}};
            r_frame_err <= 1'b0;
            r_err_count <= {ERR_W{1'b0}};
        end else begin
            r_wr_strobe <= r_wr_sel;
            r_frame_err <= r_err_pend;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_wr_sel[i]) begin
                    r_regs[i*DATA_W +: DATA_W] <= r_wr_data;
                end
            end
            if (r_err_pend && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign cipo      = r_cipo;
    assign cipo_oe   = r_cipo_oe;
    assign regs_out  = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Table-driven bench for spi_regfile_peripheral with a scoreboard queue of expected
// strobe/error events checked by a monitor, plus hand-written reset and saturation sequences.
module tb_spi_regfile_peripheral;

    localparam int S      = 2;
    localparam int HALF   = 60;
    localparam int EV_NONE = 0;
    localparam int EV_WR   = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        int         ev;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [4:0]  strobe;
        logic        err;
        logic [39:0] regs;
    } evt_t;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        copi;
    logic        cipo;
    logic        cipo_oe;
    logic [39:0] regs_out;
    logic [4:0]  wr_strobe;
    logic        frame_err;
    logic [7:0]  err_count;

    int          n_checks;
    int          n_errors;
    evt_t        sb_q[$];
    logic [39:0] model_regs;
    int          exp_err_cnt;
    vec_t        vecs[13];

    spi_regfile_peripheral #(
        .ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(S), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .frame_err(frame_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe/error pulse must match the oldest expected event.
    always @(posedge clk) begin
        #1;
        if (!rst && ((wr_strobe != 5'd0) || frame_err)) begin
            chk("wr_onehot", 64'($countones(wr_strobe) <= 1), 64'd1);
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {58'd0, wr_strobe, frame_err}, 64'd0);
            end else begin
                evt_t e;
                e = sb_q.pop_front();
                chk("evt_strobe", {59'd0, wr_strobe}, {59'd0, e.strobe});
                chk("evt_err", {63'd0, frame_err}, {63'd0, e.err});
                chk("evt_regs", {24'd0, regs_out}, {24'd0, e.regs});
            end
        end
    end

    task automatic send_bit(input logic b);
        copi = b;
        #HALF;
    endtask

    task automatic send_frame(input logic [15:0] frame, input int nbits,
                              output logic [15:0] rd, output int lat);
        rd   = 16'd0;
        lat  = 0;
        cs_n = 1'b0;
        #HALF;
        chk("cipo_oe_active", {63'd0, cipo_oe}, 64'd1);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? frame[15-i] : 1'b0;
            #HALF;
            if (i < 16) rd[15-i] = cipo;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        cs_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if ((wr_strobe != 5'd0) || frame_err) begin
                lat = k;
                break;
            end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("cipo_oe_idle", {63'd0, cipo_oe}, 64'd0);
        chk("cipo_idle", {63'd0, cipo}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] rd;
        int          lat;
        if (v.ev == EV_WR) begin
            model_regs[v.addr*8 +: 8] = v.data;
            sb_q.push_back('{5'b00001 << v.addr, 1'b0, model_regs});
        end else if (v.ev == EV_ERR) begin
            sb_q.push_back('{5'b00000, 1'b1, model_regs});
            if (exp_err_cnt < 255) exp_err_cnt++;
        end
        send_frame({v.rw, v.addr, v.data}, v.nbits, rd, lat);
        chk("cipo_data", {48'd0, rd}, {56'd0, v.exp_rd});
        if (v.ev == EV_WR) chk("wr_latency", 64'(lat), 64'(S + 2));
        chk("regs_out", {24'd0, regs_out}, {24'd0, model_regs});
        chk("err_count", {56'd0, err_count}, 64'(exp_err_cnt));
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        #HALF;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        v;
        logic [15:0] f;
        n_checks    = 0;
        n_errors    = 0;
        model_regs  = 40'd0;
        exp_err_cnt = 0;

        //               rw    addr    data   nbits ev      exp_rd
        vecs[0]  = '{1'b1, 7'h02, 8'hA5, 16, EV_WR,   8'h00};
        vecs[1]  = '{1'b1, 7'h00, 8'h3C, 16, EV_WR,   8'h00};
        vecs[2]  = '{1'b0, 7'h00, 8'h00, 16, EV_NONE, 8'h3C};
        vecs[3]  = '{1'b0, 7'h7F, 8'h00, 16, EV_NONE, 8'h00};
        vecs[4]  = '{1'b1, 7'h10, 8'h55, 16, EV_NONE, 8'h00};
        vecs[5]  = '{1'b1, 7'h01, 8'h77, 15, EV_ERR,  8'h00};
        vecs[6]  = '{1'b1, 7'h01, 8'h77, 17, EV_ERR,  8'h00};
        vecs[7]  = '{1'b0, 7'h02, 8'hFF, 16, EV_NONE, 8'hA5};
        vecs[8]  = '{1'b1, 7'h04, 8'hC3, 16, EV_WR,   8'h00};
        vecs[9]  = '{1'b0, 7'h04, 8'h00, 16, EV_NONE, 8'hC3};
        vecs[10] = '{1'b1, 7'h05, 8'hFF, 16, EV_NONE, 8'h00};
        vecs[11] = '{1'b0, 7'h05, 8'h00, 16, EV_NONE, 8'h00};
        vecs[12] = '{1'b0, 7'h01, 8'h00, 16, EV_NONE, 8'h00};

        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        copi = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_regs", {24'd0, regs_out}, 64'd0);
        chk("rst_strobe", {59'd0, wr_strobe}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("rst_err_count", {56'd0, err_count}, 64'd0);
        chk("rst_cipo", {62'd0, cipo, cipo_oe}, 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // 256 three-bit frames drive the error counter into saturation.
        v = '{1'b1, 7'h00, 8'h00, 3, EV_ERR, 8'h00};
        for (int i = 0; i < 256; i++) begin
            run_vec(v);
        end
        chk("err_saturated", {56'd0, err_count}, 64'd255);

        // Reset part-way through a write to reg1 while cs_n stays low.
        f    = {1'b1, 7'h01, 8'h99};
        cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < 9; i++) begin
            send_bit(f[15-i]);
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_regs  = 40'd0;
        exp_err_cnt = 0;
        for (int i = 9; i < 16; i++) begin
            send_bit(f[15-i]);
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        cs_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("mid_rst_regs", {24'd0, regs_out}, 64'd0);
        chk("mid_rst_err_count", {56'd0, err_count}, 64'd0);
        chk("mid_rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("mid_rst_sb", 64'(sb_q.size()), 64'd0);
        #HALF;
        run_vec('{1'b1, 7'h01, 8'h99, 16, EV_WR, 8'h00});
        run_vec('{1'b0, 7'h01, 8'h00, 16, EV_NONE, 8'h99});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
